// File: rtl/bus_dest_regfile.sv
// Write-back end of the 16-bit data bus: a 2-entry staging FIFO feeding ten
// destination registers q0..q9, with retired-write counting and first-error capture.
module bus_dest_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [3:0]       dest,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             commit_en,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [7:0]       wr_count,
    output logic             err,
    output logic [3:0]       err_dest,
    input  logic             err_clr,
    output logic             busy
);

    localparam int NUM_REGS = 10;

    // Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
    // wr_ready depends only on registered occupancy, never on wr_valid.
    logic [WIDTH-1:0] r_fifo_data [DEPTH];
    logic [3:0]       r_fifo_dest [DEPTH];
    logic             r_head;
    logic [1:0]       r_count;

    logic [WIDTH-1:0] r_q [NUM_REGS];
    logic [7:0]       r_wr_count;
    logic             r_err;
    logic [3:0]       r_err_dest;

    logic             w_push;
    logic             w_pop;
    logic             w_tail;
    logic [WIDTH-1:0] w_head_data;
    logic [3:0]       w_head_dest;
    logic             w_head_legal;

    assign wr_ready     = (r_count < 2'(DEPTH));
    assign w_push       = wr_valid && wr_ready;
    assign w_pop        = commit_en && (r_count != 2'd0);
    assign w_tail       = r_head ^ r_count[0];
    assign w_head_data  = r_fifo_data[r_head];
    assign w_head_dest  = r_fifo_dest[r_head];
    assign w_head_legal = (w_head_dest <= 4'd9);

    // Entry storage carries no reset; emptiness is tracked solely by r_count.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_fifo_data[w_tail] <= bus_in;
            r_fifo_dest[w_tail] <= dest;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_q[i] <= '0;
            end
            r_wr_count <= 8'd0;
        end else if (w_pop && w_head_legal) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_head_dest == 4'(i)) begin
                    r_q[i] <= w_head_data;
                end
            end
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    // A retiring illegal code takes priority over a same-cycle err_clr.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_dest <= 4'd0;
        end else if (w_pop && !w_head_legal) begin
            if (!r_err || err_clr) begin
                r_err      <= 1'b1;
                r_err_dest <= w_head_dest;
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_dest <= 4'd0;
        end
    end

    assign q0       = r_q[0];
    assign q1       = r_q[1];
    assign q2       = r_q[2];
    assign q3       = r_q[3];
    assign q4       = r_q[4];
    assign q5       = r_q[5];
    assign q6       = r_q[6];
    assign q7       = r_q[7];
    assign q8       = r_q[8];
    assign q9       = r_q[9];
    assign wr_count = r_wr_count;
    assign err      = r_err;
    assign err_dest = r_err_dest;
    assign busy     = (r_count != 2'd0);

endmodule

// File: tb/tb_bus_dest_regfile.sv
// Self-checking bench for bus_dest_regfile: directed scenarios plus random traffic
// compared against a queue-based reference model of the staging FIFO and registers.
module tb_bus_dest_regfile;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] bus_in;
  logic [3:0]  dest;
  logic        wr_valid;
  logic        wr_ready;
  logic        commit_en;
  logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9;
  logic [7:0]  wr_count;
  logic        err;
  logic [3:0]  err_dest;
  logic        err_clr;
  logic        busy;

  bus_dest_regfile #(.WIDTH(16), .DEPTH(2)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus_in   (bus_in),
    .dest     (dest),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .commit_en(commit_en),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q5(q5), .q6(q6), .q7(q7), .q8(q8), .q9(q9),
    .wr_count (wr_count),
    .err      (err),
    .err_dest (err_dest),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  logic [15:0] dq [10];
  assign dq[0] = q0; assign dq[1] = q1; assign dq[2] = q2; assign dq[3] = q3;
  assign dq[4] = q4; assign dq[5] = q5; assign dq[6] = q6; assign dq[7] = q7;
  assign dq[8] = q8; assign dq[9] = q9;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // exp_q holds pending writes as {dest, data}, oldest first.
  logic [19:0] exp_q [$];
  logic [15:0] m_regs [10];
  logic [7:0]  m_cnt;
  logic        m_err;
  logic [3:0]  m_err_dest;

  typedef logic [174:0] snap_t;

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < 10; i++) m_regs[i] = 16'h0;
    m_cnt      = 8'd0;
    m_err      = 1'b0;
    m_err_dest = 4'd0;
  endfunction

  // One rising edge: decisions use pre-edge occupancy, then pop, then push.
  function automatic void model_edge();
    logic        do_pop;
    logic        do_push;
    logic        bad_retire;
    logic [19:0] e;
    int          idx;
    do_pop     = commit_en && (exp_q.size() > 0);
    do_push    = wr_valid && (exp_q.size() < 2);
    bad_retire = 1'b0;
    if (do_pop) begin
      e   = exp_q.pop_front();
      idx = int'(e[19:16]);
      if (idx < 10) begin
        m_regs[idx] = e[15:0];
        m_cnt       = m_cnt + 8'd1;
      end else begin
        bad_retire = 1'b1;
        if (!m_err || err_clr) begin
          m_err      = 1'b1;
          m_err_dest = e[19:16];
        end
      end
    end
    if (err_clr && !bad_retire) begin
      m_err      = 1'b0;
      m_err_dest = 4'd0;
    end
    if (do_push) exp_q.push_back({dest, bus_in});
  endfunction

  function automatic snap_t model_snap();
    return {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4],
            m_regs[5], m_regs[6], m_regs[7], m_regs[8], m_regs[9],
            m_cnt, m_err, m_err_dest, (exp_q.size() != 0), (exp_q.size() < 2)};
  endfunction

  function automatic snap_t dut_snap();
    return {q0, q1, q2, q3, q4, q5, q6, q7, q8, q9,
            wr_count, err, err_dest, busy, wr_ready};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    err_clr  = 1'b0;
    dest     = 4'd0;
    bus_in   = 16'h0;
  endtask

  // Asserts reset between edges and checks that clearing happens without a clock.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL reset_async_state: got %h expected %h", dut_snap(), model_snap());
    end
    vectors++;
    if ({wr_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ready_busy: got %b expected 10", {wr_ready, busy});
    end
    #4;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1;
    idle_inputs();
    commit_en = 1'b1;
    model_reset();
    #2;
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL power_on_reset: got %h expected %h", dut_snap(), model_snap());
    end
    #5;
    reset = 1'b0;
    d = 16'($urandom_range(1, 16'hFFFF));
    wr_valid = 1'b1; dest = 4'd2; bus_in = d;
    cycle();
    wr_valid = 1'b0;
    cycle();
    vectors++;
    if (q2 !== d) begin
      miscompares++;
      $display("FAIL pre_reset_write: got %h expected %h", q2, d);
    end
    pulse_reset();
  endtask

  task automatic test_basic_writes();
    commit_en = 1'b1;
    for (int d = 0; d < 10; d++) begin
      wr_valid = 1'b1;
      dest     = 4'(d);
      bus_in   = 16'h1000 + 16'(d);
      cycle();
      if (d > 0) begin
        vectors++;
        if (dq[d-1] !== 16'h1000 + 16'(d - 1)) begin
          miscompares++;
          $display("FAIL basic_q%0d: got %h expected %h", d - 1, dq[d-1], 16'h1000 + 16'(d - 1));
        end
      end
      vectors++;
      if (wr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_ready: got %b expected 1", wr_ready);
      end
    end
    idle_inputs();
    cycle();
    vectors++;
    if (q9 !== 16'h1009 || wr_count !== 8'd10) begin
      miscompares++;
      $display("FAIL basic_final: got q9=%h cnt=%0d expected q9=1009 cnt=10", q9, wr_count);
    end
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL basic_snapshot: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_stall();
    commit_en = 1'b0;
    wr_valid = 1'b1; dest = 4'd3; bus_in = 16'hAAAA;
    cycle();
    bus_in = 16'h5555;
    cycle();
    vectors++;
    if ({wr_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_full: got ready,busy=%b expected 01", {wr_ready, busy});
    end
    dest = 4'd7; bus_in = 16'h0001;
    cycle();
    vectors++;
    if ({wr_ready, busy} !== 2'b01 || q3 !== 16'h1003) begin
      miscompares++;
      $display("FAIL stall_hold: got ready,busy=%b q3=%h expected 01 1003", {wr_ready, busy}, q3);
    end
    commit_en = 1'b1;
    cycle();
    vectors++;
    if (q3 !== 16'hAAAA || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first_retire: got q3=%h ready=%b expected AAAA 1", q3, wr_ready);
    end
    cycle();
    wr_valid = 1'b0;
    vectors++;
    if (q3 !== 16'h5555) begin
      miscompares++;
      $display("FAIL stall_second_retire: got %h expected 5555", q3);
    end
    cycle();
    vectors++;
    if (q7 !== 16'h0001 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_third: got q7=%h busy=%b expected 0001 0", q7, busy);
    end
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL stall_snapshot: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_illegal();
    commit_en = 1'b1;
    wr_valid = 1'b1; dest = 4'd12; bus_in = 16'($urandom);
    cycle();
    dest = 4'd15; bus_in = 16'($urandom);
    cycle();
    wr_valid = 1'b0;
    vectors++;
    if ({err, err_dest} !== {1'b1, 4'd12}) begin
      miscompares++;
      $display("FAIL illegal_first: got err=%b dest=%0d expected 1 12", err, err_dest);
    end
    cycle();
    vectors++;
    if ({err, err_dest} !== {1'b1, 4'd12} || wr_count !== 8'd13) begin
      miscompares++;
      $display("FAIL illegal_sticky: got err=%b dest=%0d cnt=%0d expected 1 12 13", err, err_dest, wr_count);
    end
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL illegal_snapshot: got %h expected %h", dut_snap(), model_snap());
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    vectors++;
    if ({err, err_dest} !== 5'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got err=%b dest=%0d expected 0 0", err, err_dest);
    end
  endtask

  task automatic test_clr_same_edge();
    commit_en = 1'b1;
    wr_valid = 1'b1; dest = 4'd13; bus_in = 16'($urandom);
    cycle();
    dest = 4'd11;
    cycle();
    wr_valid = 1'b0;
    err_clr  = 1'b1;
    cycle();
    err_clr = 1'b0;
    vectors++;
    if ({err, err_dest} !== {1'b1, 4'd11}) begin
      miscompares++;
      $display("FAIL clr_same_edge: got err=%b dest=%0d expected 1 11", err, err_dest);
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    commit_en = 1'b0;
    wr_valid = 1'b1; dest = 4'd4; bus_in = 16'($urandom_range(1, 16'hFFFF));
    cycle();
    dest = 4'd8; bus_in = 16'($urandom_range(1, 16'hFFFF));
    cycle();
    idle_inputs();
    vectors++;
    if ({wr_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL inflight_full: got ready,busy=%b expected 01", {wr_ready, busy});
    end
    pulse_reset();
    commit_en = 1'b1;
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (dq[i] !== 16'h0) begin
        miscompares++;
        $display("FAIL inflight_q%0d: got %h expected 0000", i, dq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    commit_en = 1'b1;
    wr_valid  = 1'b1;
    for (int i = 0; i < 257; i++) begin
      dest   = 4'($urandom_range(0, 9));
      bus_in = 16'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();
    vectors++;
    if (wr_count !== 8'd1) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected 1", wr_count);
    end
    vectors++;
    if (dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL wrap_snapshot: got %h expected %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      wr_valid  = ($urandom_range(0, 3) != 0);
      commit_en = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      dest      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      bus_in    = 16'($urandom);
      cycle();
      vectors++;
      if (dut_snap() !== model_snap()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_snap(), model_snap());
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_writes();
    test_stall();
    test_illegal();
    test_clr_same_edge();
    test_reset_in_flight();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
